// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_pkg
// Purpose  : Shared types and constants for the RV32M multiply/divide
//            sequencer: funct3 operation codes, sequencer states and the
//            decoder steering constants for M-extension instructions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Decoder steering: R-type opcode with funct7 = 0000001 selects this block
    localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
    localparam logic [6:0] F7_MULDIV      = 7'b0000001;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div_op(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_if
// Purpose  : Request/response bundle between the execute stage (master) and
//            the multiply/divide sequencer (slave).
// Signals  : in_valid/in_ready/funct3/op_a/op_b  - request handshake
//            out_valid/out_ready/result          - response handshake
//            busy                                 - sequencer computing
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int N = 32
);
    logic             in_valid;
    logic             in_ready;
    muldiv_op_e       funct3;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     result;
    logic             busy;

    modport master (
        output in_valid, funct3, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : Combinational single iteration of the iterative datapath.
//            Multiply: one LSB-first shift-add step on a 2N accumulator
//            {i_hi, i_lo}, where i_lo still holds the unconsumed multiplier.
//            Divide: one MSB-first restoring step; i_hi is the partial
//            remainder, i_lo shifts the dividend out and the quotient in.
// Ports    : i_div  - 1 selects the divide step, 0 the multiply step
//            i_hi   - upper accumulator half / partial remainder
//            i_lo   - lower accumulator half / dividend-quotient shifter
//            i_opnd - multiplicand magnitude / divisor magnitude
//            o_hi, o_lo - updated halves
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int N = 32
) (
    input  wire logic         i_div,
    input  wire logic [N-1:0] i_hi,
    input  wire logic [N-1:0] i_lo,
    input  wire logic [N-1:0] i_opnd,
    output logic      [N-1:0] o_hi,
    output logic      [N-1:0] o_lo
);
    logic [N:0]   w_sum;
    logic [N:0]   w_shift;
    logic         w_ge;
    logic [N-1:0] w_sub;

    // Shift-add: carry out of the upper half becomes the new MSB after the
    // right shift, so the sum is kept one bit wider.
    assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(N+1){1'b0}});

    // Restoring divide: the shifted partial remainder needs N+1 bits. When the
    // subtraction succeeds the difference is below the divisor, so the low N
    // bits of the wrap-around subtraction are exact.
    assign w_shift = {i_hi, i_lo[N-1]};
    assign w_ge    = (w_shift >= {1'b0, i_opnd});
    assign w_sub   = w_shift[N-1:0] - i_opnd;

    always_comb begin
        o_hi = w_sum[N:1];
        o_lo = {w_sum[0], i_lo[N-1:1]};
        if (i_div) begin
            o_hi = w_ge ? w_sub : w_shift[N-1:0];
            o_lo = {i_lo[N-2:0], w_ge};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Multi-cycle RV32M multiply/divide sequencer. Accepts one
//            operation, iterates N shift-add / restoring-divide steps on
//            operand magnitudes, applies sign fixup, then holds the result
//            until the consumer takes it. Divide-by-zero and signed overflow
//            bypass the iteration and complete one cycle after acceptance.
// Ports    : clk   - clock
//            rst_n - synchronous active-low reset
//            flush - synchronous abort, highest priority
//            bus   - muldiv_seq_if slave (request/response handshake, busy)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    flush,
    muldiv_seq_if.slave  bus
);
    localparam int            CW         = $clog2(N);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(N - 1);

    muldiv_state_e  r_state;
    logic [CW-1:0]  r_cnt;
    muldiv_op_e     r_op;
    logic           r_neg_a;
    logic           r_neg_b;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic [N-1:0]   r_opnd;
    logic [N-1:0]   r_result;

    // ---------------- acceptance decode ----------------
    logic           w_a_signed;
    logic           w_b_signed;
    logic           w_neg_a;
    logic           w_neg_b;
    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic           w_div0;
    logic           w_ovf;
    logic [N-1:0]   w_special_res;

    assign w_a_signed = (bus.funct3 != OP_MULHU) && (bus.funct3 != OP_DIVU) &&
                        (bus.funct3 != OP_REMU);
    assign w_b_signed = (bus.funct3 == OP_MUL) || (bus.funct3 == OP_MULH) ||
                        (bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM);
    assign w_neg_a    = w_a_signed && bus.op_a[N-1];
    assign w_neg_b    = w_b_signed && bus.op_b[N-1];
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign w_mag_a    = w_neg_a ? -bus.op_a : bus.op_a;
    assign w_mag_b    = w_neg_b ? -bus.op_b : bus.op_b;

    assign w_div0 = is_div_op(bus.funct3) && (bus.op_b == '0);
    assign w_ovf  = ((bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM)) &&
                    (bus.op_a == {1'b1, {(N-1){1'b0}}}) && (&bus.op_b);

    // funct3[1] distinguishes REM/REMU from DIV/DIVU within the divide family
    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = bus.funct3[1] ? bus.op_a : '1;
        else if (w_ovf)
            w_special_res = bus.funct3[1] ? '0 : bus.op_a;
    end

    // ---------------- iteration datapath ----------------
    logic [N-1:0] w_step_hi;
    logic [N-1:0] w_step_lo;

    muldiv_step #(.N(N)) u_step (
        .i_div  (r_op[2]),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_step_hi),
        .o_lo   (w_step_lo)
    );

    // ---------------- sign fixup ----------------
    logic           w_neg_res;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;
    logic [N-1:0]   w_fix_res;

    // Unsigned operands never latch a negative sign, so one XOR covers
    // every signed/unsigned combination.
    assign w_neg_res  = r_neg_a ^ r_neg_b;
    assign w_prod_fix = w_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo_fix  = w_neg_res ? -r_lo : r_lo;
    assign w_rem_fix  = r_neg_a   ? -r_hi : r_hi;

    always_comb begin
        w_fix_res = w_prod_fix[N-1:0];
        case (r_op)
            OP_MUL:                       w_fix_res = w_prod_fix[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*N-1:N];
            OP_DIV, OP_DIVU:              w_fix_res = w_quo_fix;
            OP_REM, OP_REMU:              w_fix_res = w_rem_fix;
            default:                      w_fix_res = w_prod_fix[N-1:0];
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op    <= bus.funct3;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        // Multiply keeps the multiplier in the shifter and the
                        // multiplicand as the addend; divide swaps the roles.
                        if (is_div_op(bus.funct3)) begin
                            r_lo   <= w_mag_a;
                            r_opnd <= w_mag_b;
                        end else begin
                            r_lo   <= w_mag_b;
                            r_opnd <= w_mag_a;
                        end
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.result    = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq: directed RV32M cases,
//            special cases, backpressure, flush/reset aborts and randomized
//            operations against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq_if #(.N(N)) bus ();

    muldiv_seq #(.N(N)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics using 64-bit arithmetic
    function automatic logic [31:0] model(input muldiv_op_e f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint          p;
        longint unsigned up;
        case (f)
            OP_MUL:    begin p = sa * sb;           return p[31:0];  end
            OP_MULH:   begin p = sa * sb;           return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin up = ua * ub;          return up[63:32]; end
            OP_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            OP_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
            OP_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default:   begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
        endcase
    endfunction

    function automatic bit is_special(input muldiv_op_e f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return ((f == OP_DIV) || (f == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Called at a negedge with the DUT idle. Latency is the cycle number of
    // the first out_valid relative to the acceptance edge (edge k -> cycle k+1).
    task automatic run_op(input muldiv_op_e f, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        int exp_lat;
        exp_lat = is_special(f, a, b) ? 1 : N + 2;
        check({tag, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.op_a     = a;
        bus.op_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_result"}, bus.result, model(f, a, b));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_after"}, bus.in_ready, 1);
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_wait_valid"}, bus.out_valid, 1);
    endtask

    initial begin
        logic [31:0] corner [5];
        logic [31:0] ra, rb;
        muldiv_op_e  rf;
        bit          seen;

        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        bus.in_valid  = 1'b0;
        bus.funct3    = OP_MUL;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_result",    bus.result, 0);

        // Directed cases
        run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, "mul_7_m3");
        run_op(OP_MULH,   32'd7,          32'hFFFF_FFFD, "mulh_7_m3");
        check("mulh_7_m3_const", bus.result, 32'hFFFF_FFFF);
        run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu_max");
        check("mulhu_max_const", bus.result, 32'hFFFF_FFFE);
        run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         "mulhsu_m1_2");
        run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         "div_m7_2");
        check("div_m7_2_const", bus.result, 32'hFFFF_FFFD);
        run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         "rem_m7_2");
        run_op(OP_DIVU,   32'd100,        32'd7,         "divu_100_7");
        check("divu_100_7_const", bus.result, 32'd14);
        run_op(OP_REMU,   32'd100,        32'd7,         "remu_100_7");
        check("remu_100_7_const", bus.result, 32'd2);

        // Special cases
        run_op(OP_DIV,    32'd5,          32'd0,         "div_by0");
        run_op(OP_REMU,   32'd5,          32'd0,         "remu_by0");
        run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
        run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");

        // Backpressure: hold the result 10 cycles while a request waits
        bus.in_valid = 1'b1;
        bus.funct3   = OP_DIVU;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid("bp");
        bus.in_valid = 1'b1;
        bus.funct3   = OP_MUL;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result_hold", bus.result, 32'd14);
            check("bp_valid_hold",  bus.out_valid, 1);
            check("bp_in_ready",    bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_idle",  bus.in_ready, 1);
        check("bp_release_busy",  bus.busy, 0);
        check("bp_release_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_accept_busy", bus.busy, 1);
        wait_valid("bp2");
        check("bp2_result", bus.result, 32'd15);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Flush during CALC, with a competing request in the flush cycle
        bus.in_valid = 1'b1;
        bus.funct3   = OP_MUL;
        bus.op_a     = 32'd123;
        bus.op_b     = 32'd456;
        @(negedge clk);
        bus.funct3 = OP_DIVU;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd3;
        repeat (4) @(negedge clk);
        check("fl_busy_before", bus.busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_busy",      bus.busy, 0);
        check("fl_in_ready",  bus.in_ready, 1);
        check("fl_out_valid", bus.out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        check("fl_no_activity", seen, 0);

        // Reset during CALC
        bus.in_valid = 1'b1;
        bus.funct3   = OP_MULHU;
        bus.op_a     = 32'hDEAD_BEEF;
        bus.op_b     = 32'h1234_5678;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rr_in_ready",  bus.in_ready, 1);
        check("rr_out_valid", bus.out_valid, 0);
        check("rr_busy",      bus.busy, 0);
        check("rr_result",    bus.result, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rf = muldiv_op_e'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            run_op(rf, ra, rb, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation through a valid/ready handshake and runs an iterative shift-add multiplier or restoring divider for N steps. It applies sign and special-case fixups, then holds the result until the memory-side consumer takes it. While it is busy the execute stage stalls decode through `in_ready`.

## Interface
- `N`, 32, operand/result width; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous abort from pipeline control.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  N  rs1 value (multiplicand/dividend).
- `op_b`  in  N  rs2 value (multiplier/divisor).
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  N  final result; stable while `out_valid` is high.
- `busy`  out  1  high in CALC or FIX.

## Operation
- States:
  - IDLE
  - CALC: N iterations.
  - FIX: sign fixup.
  - DONE: hold result.
- Transitions:
  - IDLE→CALC on `in_valid && in_ready` for a normal operation.
  - IDLE→DONE on `in_valid && in_ready` for a special case.
  - CALC→FIX when the step counter reaches N−1.
  - FIX→DONE unconditionally.
  - DONE→IDLE on `out_ready`.
- Acceptance latches `funct3`, the operand signs and the operand magnitudes:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply: unsigned shift-add on magnitudes with a 2N-bit accumulator, one multiplier bit per cycle (LSB first).
  - FIX negates the 2N product if the operand signs differ.
  - MUL returns product[N−1:0]; MULH* return product[2N−1:N].
- Divide: restoring, one quotient bit per cycle (MSB first), with an (N+1)-bit partial remainder.
  - FIX negates the quotient if the signs differ (DIV only).
  - FIX gives the remainder the sign of the dividend (REM only).
- Special cases bypass CALC/FIX and load `result` directly at acceptance:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → `op_a`.
  - Signed overflow (`op_a` = 1 followed by N−1 zeros, `op_b` = all ones): DIV → `op_a`; REM → 0.
- Step counter is $clog2(N) bits; it clears on entry to CALC and never wraps within an operation.
- `flush` takes priority over everything, in any state:
  - Next state is IDLE; `out_valid` drops.
  - Nothing is accepted in the flush cycle, even if `in_valid` is high.
  - Partial results are discarded.
- Reset (`rst_n` low at an edge), including mid-operation:
  - State IDLE, counter 0, `result` 0, `out_valid` 0, `busy` 0.
  - `in_ready` is 1 after reset.

## Timing
- Acceptance at edge k.
  - Normal operation: CALC during cycles k+1 … k+N, FIX at cycle k+N+1, `out_valid` high from cycle k+N+2. That is N+2 cycles of latency (34 for N=32).
  - Special case: `out_valid` high from cycle k+1.
- `in_ready` is combinational from state only; there is no dependence on `in_valid`.
- DONE with `out_ready` low: `result` and `out_valid` hold indefinitely.
- DONE→IDLE on the `out_ready` edge. The earliest next acceptance is the following edge; there is no same-cycle back-to-back.
- All outputs are registered or state-decoded; there are no combinational input→output paths except none (`in_ready` from state only).

## Structure
- `riscv_pkg` additions:
  - `muldiv_op_e` enum: the eight funct3 codes.
  - `muldiv_state_e` enum: IDLE, CALC, FIX, DONE.
  - `OPCODE_REG_REG` reuse.
  - `F7_MULDIV` = 7'b0000001, for the decoder's steering.
- One sub-module, `muldiv_step`. It is a combinational single-iteration datapath (one shift-add or one restore-subtract) instantiated once. The FSM, counter, sign latches and fixup stay in `muldiv_seq`.

## Test plan
- MUL 7 × −3, then MULH on the same operands:
  - MUL → `result` 0xFFFFFFEB, with `out_valid` exactly 34 cycles after acceptance.
  - MULH → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases, each with `out_valid` one cycle after acceptance:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM 0x80000000 / −1 → 0.
- Backpressure: hold `out_ready` low 10 cycles in DONE.
  - `result` stays stable and `in_ready` stays 0; a request presented meanwhile is not accepted.
  - After `out_ready`, the request is accepted one cycle later.
- Abort during CALC (cycle 5):
  - Assert `flush` with `in_valid` high → IDLE next cycle, no acceptance that cycle, `out_valid` never rises.
  - Repeat with `rst_n` low → all outputs at reset values.
